// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, NOP, opcodes and the IF/ID FSM state type.
package mips_pkg;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        RUN,
        STALL
    } state_t;

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
module hazard_detect
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    // Both source fields are compared for every opcode; a false stall only costs a cycle.
    always_comb begin
        lu = (state == RUN) && id_valid && ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field split, load-use stall and branch flush.
// Optional macro BRANCH_DELAY_SLOT_EN: flush is ignored and the delay-slot instruction is kept.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_pc_plus4,
    input  logic [31:0]      if_instr,
    input  logic             hold,
    input  logic             flush,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    output logic             pc_write,
    output logic             id_bubble,
    output logic             id_valid,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_instr,
    output logic [5:0]       id_opcode,
    output logic [4:0]       id_rs,
    output logic [4:0]       id_rt,
    output logic [4:0]       id_rd,
    output logic [4:0]       id_shamt,
    output logic [5:0]       id_funct,
    output logic [15:0]      id_imm16,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, next_state;
    logic   lu, fl;
    logic   ld_fetch, ld_nop, cnt_inc;

    hazard_detect u_hazard_detect (
        .state       (state),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .lu          (lu)
    );

`ifdef BRANCH_DELAY_SLOT_EN
    assign fl = flush & 1'b0;
`else
    // A branch whose operand is still being loaded must stall rather than resolve.
    assign fl = flush & ~lu;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b1;
        id_bubble  = 1'b0;
        ld_fetch   = 1'b0;
        ld_nop     = 1'b0;
        cnt_inc    = 1'b0;
        if (hold) begin
            pc_write = 1'b0;
        end else if (lu) begin
            pc_write   = 1'b0;
            id_bubble  = 1'b1;
            next_state = STALL;
            cnt_inc    = 1'b1;
        end else begin
            next_state = RUN;
            if (fl) ld_nop   = 1'b1;
            else    ld_fetch = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc_plus4 <= '0;
            stall_count <= '0;
        end else begin
            if (ld_fetch) begin
                id_valid    <= if_valid;
                id_instr    <= if_valid ? if_instr : NOP;
                id_pc_plus4 <= if_pc_plus4;
            end else if (ld_nop) begin
                id_valid    <= 1'b0;
                id_instr    <= NOP;
                id_pc_plus4 <= if_pc_plus4;
            end
            if (cnt_inc && (stall_count != '1))
                stall_count <= stall_count + CNT_ONE;
        end
    end

    always_comb begin
        id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
        id_rs     = id_instr[RS_MSB:RS_LSB];
        id_rt     = id_instr[RT_MSB:RT_LSB];
        id_rd     = id_instr[RD_MSB:RD_LSB];
        id_shamt  = id_instr[SHAMT_MSB:SHAMT_LSB];
        id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];
        id_imm16  = id_instr[IMM_MSB:IMM_LSB];
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Table-driven, scoreboarded bench for if_id_stage, plus a narrow-counter instance for saturation.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, hold, flush, ex_mem_read;
    logic [31:0] if_pc_plus4, if_instr;
    logic [4:0]  ex_rt;
    logic        pc_write, id_bubble, id_valid;
    logic [31:0] id_pc_plus4, id_instr;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm16, stall_count;

    logic        reset2, if_valid2, ex_mem_read2;
    logic [31:0] if_instr2;
    logic [4:0]  ex_rt2;
    logic        pc_write2, id_bubble2, id_valid2;
    logic [31:0] id_pc_plus42, id_instr2;
    logic [5:0]  id_opcode2, id_funct2;
    logic [4:0]  id_rs2, id_rt2, id_rd2, id_shamt2;
    logic [15:0] id_imm162;
    logic [1:0]  stall_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc_plus4(if_pc_plus4),
        .if_instr(if_instr), .hold(hold), .flush(flush), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .pc_write(pc_write), .id_bubble(id_bubble), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_funct(id_funct), .id_imm16(id_imm16), .stall_count(stall_count)
    );

    if_id_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset2), .if_valid(if_valid2), .if_pc_plus4(32'h4),
        .if_instr(if_instr2), .hold(1'b0), .flush(1'b0), .ex_mem_read(ex_mem_read2),
        .ex_rt(ex_rt2), .pc_write(pc_write2), .id_bubble(id_bubble2), .id_valid(id_valid2),
        .id_pc_plus4(id_pc_plus42), .id_instr(id_instr2), .id_opcode(id_opcode2),
        .id_rs(id_rs2), .id_rt(id_rt2), .id_rd(id_rd2), .id_shamt(id_shamt2),
        .id_funct(id_funct2), .id_imm16(id_imm162), .stall_count(stall_count2)
    );

    typedef struct {
        logic        iv;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        hold;
        logic        flush;
        logic        mr;
        logic [4:0]  ert;
        logic        pcw;
        logic        bub;
        logic        v;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[16];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] pc4, input logic [31:0] instr,
                                input logic h, input logic f, input logic mr, input logic [4:0] ert,
                                input logic pcw, input logic bub, input logic v,
                                input logic [31:0] ei, input logic [31:0] ep, input logic [15:0] cnt);
        vec_t t;
        t.iv = iv; t.pc4 = pc4; t.instr = instr; t.hold = h; t.flush = f; t.mr = mr; t.ert = ert;
        t.pcw = pcw; t.bub = bub; t.v = v; t.e_instr = ei; t.e_pc4 = ep; t.cnt = cnt;
        return t;
    endfunction

    task automatic step(input vec_t t, input int idx);
        exp_t e, got;
        logic [31:0] ei;
        if_valid = t.iv; if_pc_plus4 = t.pc4; if_instr = t.instr;
        hold = t.hold; flush = t.flush; ex_mem_read = t.mr; ex_rt = t.ert;
        #4;
        chk($sformatf("v%0d pc_write", idx), {31'b0, pc_write}, {31'b0, t.pcw});
        chk($sformatf("v%0d id_bubble", idx), {31'b0, id_bubble}, {31'b0, t.bub});
        e.idx = idx; e.v = t.v; e.instr = t.e_instr; e.pc4 = t.e_pc4; e.cnt = t.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            ei = got.instr;
            chk($sformatf("v%0d id_valid", got.idx), {31'b0, id_valid}, {31'b0, got.v});
            chk($sformatf("v%0d id_instr", got.idx), id_instr, ei);
            chk($sformatf("v%0d id_pc_plus4", got.idx), id_pc_plus4, got.pc4);
            chk($sformatf("v%0d stall_count", got.idx), {16'b0, stall_count}, {16'b0, got.cnt});
            chk($sformatf("v%0d id_opcode", got.idx), {26'b0, id_opcode}, {26'b0, ei[31:26]});
            chk($sformatf("v%0d id_rs", got.idx), {27'b0, id_rs}, {27'b0, ei[25:21]});
            chk($sformatf("v%0d id_rt", got.idx), {27'b0, id_rt}, {27'b0, ei[20:16]});
            chk($sformatf("v%0d id_rd", got.idx), {27'b0, id_rd}, {27'b0, ei[15:11]});
            chk($sformatf("v%0d id_shamt", got.idx), {27'b0, id_shamt}, {27'b0, ei[10:6]});
            chk($sformatf("v%0d id_funct", got.idx), {26'b0, id_funct}, {26'b0, ei[5:0]});
            chk($sformatf("v%0d id_imm16", got.idx), {16'b0, id_imm16}, {16'b0, ei[15:0]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        if_valid = 1'b0; if_pc_plus4 = '0; if_instr = '0;
        hold = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
        if_valid2 = 1'b0; if_instr2 = '0; ex_mem_read2 = 1'b0; ex_rt2 = '0;

        //          iv  pc4       instr         hld flu mr ert  pcw bub v   e_instr       e_pc4     cnt
        tbl[0]  = mk(1, 32'h104, 32'h8C220004, 0, 0, 0, 5'd0,  1, 0, 1, 32'h8C220004, 32'h104, 16'd0);
        tbl[1]  = mk(1, 32'h108, 32'h00432020, 0, 0, 0, 5'd0,  1, 0, 1, 32'h00432020, 32'h108, 16'd0);
        tbl[2]  = mk(1, 32'h10C, 32'h12345678, 0, 0, 1, 5'd3,  0, 1, 1, 32'h00432020, 32'h108, 16'd1);
        tbl[3]  = mk(1, 32'h10C, 32'h12345678, 0, 0, 1, 5'd3,  1, 0, 1, 32'h12345678, 32'h10C, 16'd1);
        tbl[4]  = mk(1, 32'h110, 32'h00432020, 0, 0, 1, 5'd0,  1, 0, 1, 32'h00432020, 32'h110, 16'd1);
        tbl[5]  = mk(1, 32'h114, 32'h11111111, 0, 1, 1, 5'd2,  0, 1, 1, 32'h00432020, 32'h110, 16'd2);
`ifdef BRANCH_DELAY_SLOT_EN
        tbl[6]  = mk(1, 32'h118, 32'h22222222, 0, 1, 0, 5'd0,  1, 0, 1, 32'h22222222, 32'h118, 16'd2);
`else
        tbl[6]  = mk(1, 32'h118, 32'h22222222, 0, 1, 0, 5'd0,  1, 0, 0, 32'h00000000, 32'h118, 16'd2);
`endif
        tbl[7]  = mk(0, 32'h11C, 32'h33333333, 0, 0, 0, 5'd0,  1, 0, 0, 32'h00000000, 32'h11C, 16'd2);
        tbl[8]  = mk(1, 32'h120, 32'h00432020, 0, 0, 0, 5'd0,  1, 0, 1, 32'h00432020, 32'h120, 16'd2);
        tbl[9]  = mk(1, 32'h124, 32'h44444444, 0, 0, 1, 5'd3,  0, 1, 1, 32'h00432020, 32'h120, 16'd3);
        tbl[10] = mk(1, 32'h128, 32'h55555555, 1, 0, 1, 5'd3,  0, 0, 1, 32'h00432020, 32'h120, 16'd3);
        tbl[11] = mk(1, 32'h128, 32'h55555555, 1, 0, 1, 5'd3,  0, 0, 1, 32'h00432020, 32'h120, 16'd3);
        tbl[12] = mk(1, 32'h128, 32'h55555555, 1, 0, 1, 5'd3,  0, 0, 1, 32'h00432020, 32'h120, 16'd3);
        tbl[13] = mk(1, 32'h128, 32'h55555555, 0, 0, 1, 5'd3,  1, 0, 1, 32'h55555555, 32'h128, 16'd3);
        tbl[14] = mk(1, 32'h12C, 32'h66666666, 1, 0, 0, 5'd0,  0, 0, 1, 32'h55555555, 32'h128, 16'd3);
        tbl[15] = mk(1, 32'h12C, 32'h66666666, 0, 0, 1, 5'd21, 0, 1, 1, 32'h55555555, 32'h128, 16'd4);

        #3;
        chk("reset id_valid", {31'b0, id_valid}, 32'd0);
        chk("reset id_instr", id_instr, 32'd0);
        chk("reset id_pc_plus4", id_pc_plus4, 32'd0);
        chk("reset stall_count", {16'b0, stall_count}, 32'd0);
        chk("reset pc_write", {31'b0, pc_write}, 32'd1);
        chk("reset id_bubble", {31'b0, id_bubble}, 32'd0);
        #9;
        reset = 1'b0; reset2 = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) step(tbl[i], i);

        // Reset while stalled with a live instruction in ID.
        hold = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("midreset id_valid", {31'b0, id_valid}, 32'd0);
        chk("midreset id_instr", id_instr, 32'd0);
        chk("midreset stall_count", {16'b0, stall_count}, 32'd0);
        chk("midreset pc_write", {31'b0, pc_write}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // State must be RUN: a fresh load-use is detected on the first opportunity.
        step(mk(1, 32'h200, 32'h00432020, 0, 0, 0, 5'd0, 1, 0, 1, 32'h00432020, 32'h200, 16'd0), 16);
        step(mk(1, 32'h204, 32'h77777777, 0, 0, 1, 5'd2, 0, 1, 1, 32'h00432020, 32'h200, 16'd1), 17);

        // Saturation on a 2-bit counter.
        if_valid2 = 1'b1; if_instr2 = 32'h00432020; ex_mem_read2 = 1'b0; ex_rt2 = 5'd3;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
            ex_mem_read2 = 1'b1;
            #4;
            chk($sformatf("sat%0d id_bubble", k), {31'b0, id_bubble2}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d stall_count", k), {30'b0, stall_count2}, (k > 3) ? 32'd3 : k);
            ex_mem_read2 = 1'b0;
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
